// File: rtl/bcm_pkg.sv
// Shared types and sizing helpers for binary-code-modulation blocks.
package bcm_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLANE,
        S_BLANK
    } bcm_state_e;

    function automatic int unsigned plane_w(int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int unsigned plane_len(int unsigned prescale, int unsigned b);
        return prescale << b;
    endfunction

    // Counter must hold both the longest plane reload and the blanking reload.
    function automatic int unsigned cnt_w(int unsigned prescale, int unsigned width,
                                          int unsigned blank);
        int unsigned w;
        int unsigned wb;
        w  = $clog2(plane_len(prescale, width - 1));
        wb = $clog2(blank);
        if (wb > w) w = wb;
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/bcm_plane_scheduler_if.sv
// Host duty-write bus and LED-side outputs of the BCM plane scheduler.
interface bcm_plane_scheduler_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned PW = bcm_pkg::plane_w(WIDTH);

    logic                      enable;
    logic                      duty_wr;
    logic [CHANNELS*WIDTH-1:0] duty_wdata;
    logic [CHANNELS-1:0]       led;
    logic [PW-1:0]             plane;
    logic                      frame_start;
    logic                      busy;

    modport master (
        output enable, duty_wr, duty_wdata,
        input  led, plane, frame_start, busy
    );

    modport slave (
        input  enable, duty_wr, duty_wdata,
        output led, plane, frame_start, busy
    );

endinterface

// File: rtl/bcm_plane_timer.sv
// Loadable down-counter; holds at zero and flags done while zero.
module bcm_plane_timer #(
    parameter int unsigned CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/bcm_plane_scheduler.sv
// BCM scheduler: steps bit planes per frame, drives LED enables from a
// double-buffered duty register, with optional dark blanking after each plane.
module bcm_plane_scheduler
    import bcm_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned BLANK    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bcm_plane_scheduler_if.slave  sched
);

    localparam int unsigned     PW         = plane_w(WIDTH);
    localparam int unsigned     CW         = cnt_w(PRESCALE, WIDTH, BLANK);
    localparam int unsigned     DW         = CHANNELS * WIDTH;
    localparam logic [CW-1:0]   PRE_LOAD   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]   BLANK_LOAD = (BLANK > 0) ? CW'(BLANK - 1) : '0;
    localparam logic [PW-1:0]   LAST_PLANE = PW'(WIDTH - 1);

    bcm_state_e     state, state_n;
    logic [PW-1:0]  plane_q, plane_n;
    logic [DW-1:0]  shadow, active, active_n;
    logic           load;
    logic [CW-1:0]  load_value;
    logic           done;
    logic           frame_load;
    logic           plane_end;
    logic [CHANNELS-1:0] led_n, led_q;
    logic           fs_q;
    logic           busy_q;

    bcm_plane_timer #(
        .CW (CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .done       (done)
    );

    always_comb begin
        state_n    = state;
        plane_n    = plane_q;
        load       = 1'b0;
        load_value = '0;
        frame_load = 1'b0;
        plane_end  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (sched.enable) frame_load = 1'b1;
            end
            S_PLANE: begin
                if (done) begin
                    if (BLANK > 0) begin
                        state_n    = S_BLANK;
                        load       = 1'b1;
                        load_value = BLANK_LOAD;
                    end else begin
                        plane_end = 1'b1;
                    end
                end
            end
            S_BLANK: begin
                if (done) plane_end = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        if (plane_end) begin
            if (plane_q != LAST_PLANE) begin
                state_n    = S_PLANE;
                plane_n    = plane_q + PW'(1);
                load       = 1'b1;
                load_value = CW'(plane_len(PRESCALE, 32'(plane_q) + 32'd1) - 32'd1);
            end else if (sched.enable) begin
                frame_load = 1'b1;
            end else begin
                state_n = S_IDLE;
                plane_n = '0;
            end
        end

        // Frame start shared by the IDLE exit and back-to-back frames.
        if (frame_load) begin
            state_n    = S_PLANE;
            plane_n    = '0;
            load       = 1'b1;
            load_value = PRE_LOAD;
        end

        active_n = frame_load ? shadow : active;
    end

    // LEDs computed from next-cycle state so the outputs stay registered.
    always_comb begin
        led_n = '0;
        if (state_n == S_PLANE) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                led_n[ch] = active_n[ch*WIDTH + 32'(plane_n)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            plane_q <= '0;
            shadow  <= '0;
            active  <= '0;
            led_q   <= '0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            plane_q <= plane_n;
            if (sched.duty_wr) shadow <= sched.duty_wdata;
            active  <= active_n;
            led_q   <= led_n;
            fs_q    <= frame_load;
            busy_q  <= (state_n != S_IDLE);
        end
    end

    assign sched.led         = led_q;
    assign sched.plane       = plane_q;
    assign sched.frame_start = fs_q;
    assign sched.busy        = busy_q;

endmodule

// File: tb/tb_bcm_plane_scheduler.sv
// Directed bench for bcm_plane_scheduler at WIDTH=8, CHANNELS=4, PRESCALE=4, BLANK=1.
module tb_bcm_plane_scheduler;

    localparam int FRAME = 1028;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcm_plane_scheduler_if #(.WIDTH(8), .CHANNELS(4)) sched ();

    bcm_plane_scheduler #(
        .WIDTH    (8),
        .CHANNELS (4),
        .PRESCALE (4),
        .BLANK    (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (sched)
    );

    int checks = 0;
    int errors = 0;

    int l0_cnt, l0_at0, l1_cnt, l1_first, l1_last, l1_badplane;
    int l2_low, l3_cnt, extra_fs, busy_low;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_fs(string tag);
        int n;
        n = 0;
        while (sched.frame_start !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_fs_seen"}, 32'(sched.frame_start), 32'd1);
    endtask

    // Called on the frame_start sample; returns on the sample one frame later.
    task automatic measure(int wr_at, logic [31:0] wr_data, int drop_at);
        l0_cnt = 0; l0_at0 = 0; l1_cnt = 0; l1_first = -1; l1_last = -1;
        l1_badplane = 0; l2_low = 0; l3_cnt = 0; extra_fs = 0; busy_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (i > 0 && sched.frame_start) extra_fs++;
            if (!sched.busy) busy_low++;
            if (sched.led[0]) begin
                l0_cnt++;
                if (i == 0) l0_at0 = 1;
            end
            if (sched.led[1]) begin
                l1_cnt++;
                if (l1_first < 0) l1_first = i;
                l1_last = i;
                if (sched.plane != 3'd7) l1_badplane++;
            end
            if (!sched.led[2]) l2_low++;
            if (sched.led[3]) l3_cnt++;
            if (i == wr_at) begin
                sched.duty_wr    = 1'b1;
                sched.duty_wdata = wr_data;
            end else if (i == wr_at + 1) begin
                sched.duty_wr = 1'b0;
            end
            if (i == drop_at) sched.enable = 1'b0;
        end
        @(negedge clk);
        sched.duty_wr = 1'b0;
    endtask

    initial begin
        int fs_seen;
        rst              = 1'b1;
        sched.enable     = 1'b0;
        sched.duty_wr    = 1'b0;
        sched.duty_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_led",   32'(sched.led), 32'd0);
        check("rst_plane", 32'(sched.plane), 32'd0);
        check("rst_fs",    32'(sched.frame_start), 32'd0);
        check("rst_busy",  32'(sched.busy), 32'd0);
        rst = 1'b0;

        // Load shadow while idle: ch3=00 ch2=FF ch1=80 ch0=01
        sched.duty_wr    = 1'b1;
        sched.duty_wdata = 32'h00FF_8001;
        @(negedge clk);
        sched.duty_wr = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_led",  32'(sched.led), 32'd0);
        check("idle_busy", 32'(sched.busy), 32'd0);

        sched.enable = 1'b1;
        wait_fs("f1");
        measure(-1, 32'd0, -1);
        check("f1_l0_cnt",    l0_cnt, 4);
        check("f1_l0_at_fs",  l0_at0, 1);
        check("f1_l1_cnt",    l1_cnt, 512);
        check("f1_l1_first",  l1_first, 515);
        check("f1_l1_last",   l1_last, 1026);
        check("f1_l1_plane7", l1_badplane, 0);
        check("f1_l2_low",    l2_low, 8);
        check("f1_l3_cnt",    l3_cnt, 0);
        check("f1_extra_fs",  extra_fs, 0);
        check("f1_busy_low",  busy_low, 0);
        check("f1_period",    32'(sched.frame_start), 32'd1);

        // Mid-frame write of ch0=FF: current frame unaffected
        measure(100, 32'h00FF_80FF, -1);
        check("f2_l0_cnt", l0_cnt, 4);
        check("f2_period", 32'(sched.frame_start), 32'd1);

        // New duty visible; write ch0=01 on the frame-load edge
        measure(1027, 32'h00FF_8001, -1);
        check("f3_l0_cnt",  l0_cnt, 1020);
        check("f3_l2_low",  l2_low, 8);
        check("f3_l1_cnt",  l1_cnt, 512);

        measure(-1, 32'd0, -1);
        check("f4_l0_delayed", l0_cnt, 1020);

        // Enable dropped mid-frame: frame completes, then idle
        measure(-1, 32'd0, 300);
        check("f5_l0_cnt",    l0_cnt, 4);
        check("f5_l1_cnt",    l1_cnt, 512);
        check("f5_busy_low",  busy_low, 0);
        check("f5_end_fs",    32'(sched.frame_start), 32'd0);
        check("f5_end_busy",  32'(sched.busy), 32'd0);
        check("f5_end_led",   32'(sched.led), 32'd0);
        check("f5_end_plane", 32'(sched.plane), 32'd0);
        fs_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (sched.frame_start) fs_seen++;
        end
        check("idle_no_fs", fs_seen, 0);

        // Reset during plane 5
        sched.enable = 1'b1;
        wait_fs("f6");
        repeat (150) @(negedge clk);
        check("f6_plane5", 32'(sched.plane), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_led",   32'(sched.led), 32'd0);
        check("mid_rst_busy",  32'(sched.busy), 32'd0);
        check("mid_rst_plane", 32'(sched.plane), 32'd0);
        check("mid_rst_fs",    32'(sched.frame_start), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("restart_fs",    32'(sched.frame_start), 32'd1);
        check("restart_plane", 32'(sched.plane), 32'd0);
        check("restart_busy",  32'(sched.busy), 32'd1);
        measure(10, 32'h00FF_8001, -1);
        check("f7_l0_cnt",  l0_cnt, 0);
        check("f7_l1_cnt",  l1_cnt, 0);
        check("f7_l2_low",  l2_low, 1028);
        check("f7_period",  32'(sched.frame_start), 32'd1);
        measure(-1, 32'd0, -1);
        check("f8_l0_cnt",   l0_cnt, 4);
        check("f8_l1_first", l1_first, 515);
        check("f8_l2_low",   l2_low, 8);

        sched.enable = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
